alien_row_manager: RTL

- Generalised alien-row controller for the Space Invaders datapath. It tracks a parametrised row of NUM_ALIENS aliens with an alive mask and a row Y position.
- Detects box hits from the player shot and requests per-alien erase from the drawer via a req/done handshake. It periodically drops the whole row via a second handshake.
- Declares win or lose. Sits between the shot controller (shot coords in, hit pulse out) and the VGA draw FSM (erase/shift requests out, done in).

---
 rtl/space_pkg.sv | 31 +++
 rtl/alien_hit_detect.sv | 46 ++++
 rtl/alien_row_manager.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/space_pkg.sv
// Shared screen, coordinate and alien-row definitions for the Space Invaders datapath.
package space_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam int DEF_NUM_ALIENS  = 5;
    localparam int DEF_ALIEN_W     = 12;
    localparam int DEF_ALIEN_H     = 10;
    localparam int DEF_GAP         = 20;
    localparam int DEF_START_X     = 10;
    localparam int DEF_START_Y     = 10;
    localparam int DEF_DROP_LIMIT  = 40;
    localparam int DEF_DROP_CYCLES = 50000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KILL,
        ST_WAIT_KILL,
        ST_DROP,
        ST_WAIT_DROP,
        ST_WIN,
        ST_LOSE
    } state_e;

    typedef logic [X_W:0] xw_t;
    typedef logic [Y_W:0] yw_t;

endpackage

// File: rtl/alien_hit_detect.sv
// Per-alien box test of the current shot against the live row, lowest index wins.
module alien_hit_detect
    import space_pkg::*;
#(
    parameter int NUM_ALIENS = DEF_NUM_ALIENS,
    parameter int ALIEN_W    = DEF_ALIEN_W,
    parameter int ALIEN_H    = DEF_ALIEN_H,
    parameter int GAP        = DEF_GAP,
    parameter int START_X    = DEF_START_X
) (
    input  logic                  shotValid,
    input  logic [X_W-1:0]        shotX,
    input  logic [Y_W-1:0]        shotY,
    input  logic [Y_W-1:0]        rowY,
    input  logic [NUM_ALIENS-1:0] alive,
    output logic                  hitAny,
    output logic [2:0]            hitIdx
);

    logic [NUM_ALIENS-1:0] hitVec;
    xw_t sx;
    yw_t sy;
    yw_t top;
    yw_t bot;

    // One extra bit keeps rowY+ALIEN_H from wrapping at the bottom of the screen.
    assign sx  = {1'b0, shotX};
    assign sy  = {1'b0, shotY};
    assign top = {1'b0, rowY};
    assign bot = top + yw_t'(ALIEN_H);

    for (genvar g = 0; g < NUM_ALIENS; g++) begin : g_alien
        localparam xw_t L = xw_t'(START_X + g * (ALIEN_W + GAP));
        localparam xw_t R = xw_t'(START_X + g * (ALIEN_W + GAP) + ALIEN_W);
        assign hitVec[g] = shotValid & alive[g] & (sx >= L) & (sx <= R) & (sy >= top) & (sy <= bot);
    end

    always_comb begin
        hitAny = |hitVec;
        hitIdx = '0;
        for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
            if (hitVec[i]) hitIdx = 3'(i);
        end
    end

endmodule

// File: rtl/alien_row_manager.sv
// Alien row controller: hit detection, kill/drop handshakes with the drawer, win/lose.
module alien_row_manager
    import space_pkg::*;
#(
    parameter int NUM_ALIENS  = DEF_NUM_ALIENS,
    parameter int ALIEN_W     = DEF_ALIEN_W,
    parameter int ALIEN_H     = DEF_ALIEN_H,
    parameter int GAP         = DEF_GAP,
    parameter int START_X     = DEF_START_X,
    parameter int START_Y     = DEF_START_Y,
    parameter int DROP_LIMIT  = DEF_DROP_LIMIT,
    parameter int DROP_CYCLES = DEF_DROP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shotValid,
    input  logic [X_W-1:0]        shotX,
    input  logic [Y_W-1:0]        shotY,
    input  logic                  killDone,
    input  logic                  shiftDone,
    output logic                  shotHit,
    output logic                  killReq,
    output logic [2:0]            killIdx,
    output logic                  moveDown,
    output logic [X_W-1:0]        boxTopX,
    output logic [X_W-1:0]        boxBotX,
    output logic [Y_W-1:0]        boxTopY,
    output logic [Y_W-1:0]        boxBotY,
    output logic [Y_W-1:0]        rowY,
    output logic [NUM_ALIENS-1:0] alive,
    output logic [3:0]            scoreCount,
    output logic [5:0]            dropCount,
    output logic                  gameOver,
    output logic                  youWin
);

    localparam int TICK_W = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DROP_CYCLES - 1);
    localparam logic [X_W-1:0]    ROW_LEFT  = X_W'(START_X);
    localparam logic [X_W-1:0]    ROW_RIGHT = X_W'(START_X + (NUM_ALIENS - 1) * (ALIEN_W + GAP) + ALIEN_W);

    state_e                state_q, state_d;
    logic [NUM_ALIENS-1:0] alive_q, alive_d;
    logic [Y_W-1:0]        rowY_q, rowY_d;
    logic [3:0]            score_q, score_d;
    logic [5:0]            drop_q, drop_d;
    logic [2:0]            idx_q, idx_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic                  pend_q, pend_d;
    logic                  tickWrap;
    logic                  hitAny;
    logic [2:0]            hitIdx;
    logic [X_W-1:0]        killLeft;

    alien_hit_detect #(
        .NUM_ALIENS (NUM_ALIENS),
        .ALIEN_W    (ALIEN_W),
        .ALIEN_H    (ALIEN_H),
        .GAP        (GAP),
        .START_X    (START_X)
    ) u_hit (
        .shotValid (shotValid),
        .shotX     (shotX),
        .shotY     (shotY),
        .rowY      (rowY_q),
        .alive     (alive_q),
        .hitAny    (hitAny),
        .hitIdx    (hitIdx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            alive_q <= '1;
            rowY_q  <= Y_W'(START_Y);
            score_q <= '0;
            drop_q  <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= alive_d;
            rowY_q  <= rowY_d;
            score_q <= score_d;
            drop_q  <= drop_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
        end
    end

    // A tick landing in the DROP cycle is kept rather than cleared away.
    always_comb begin
        tick_d   = tick_q;
        tickWrap = 1'b0;
        if (state_q != ST_WIN && state_q != ST_LOSE) begin
            if (tick_q == TICK_LAST) begin
                tick_d   = '0;
                tickWrap = 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
        pend_d = pend_q;
        if (state_q == ST_DROP) pend_d = 1'b0;
        if (tickWrap) pend_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        rowY_d  = rowY_q;
        score_d = score_q;
        drop_d  = drop_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (drop_q == 6'(DROP_LIMIT)) begin
                    state_d = ST_LOSE;
                end else if (alive_q == '0) begin
                    state_d = ST_WIN;
                end else if (pend_q) begin
                    state_d = ST_DROP;
                end else if (hitAny) begin
                    state_d = ST_KILL;
                    idx_d   = hitIdx;
                    alive_d = alive_q & ~(NUM_ALIENS'(1) << hitIdx);
                    score_d = score_q + 1'b1;
                end
            end
            ST_KILL:      state_d = ST_WAIT_KILL;
            ST_WAIT_KILL: if (killDone) state_d = ST_IDLE;
            ST_DROP:      state_d = ST_WAIT_DROP;
            ST_WAIT_DROP: begin
                if (shiftDone) begin
                    state_d = ST_IDLE;
                    rowY_d  = rowY_q + 1'b1;
                    drop_d  = drop_q + 1'b1;
                end
            end
            ST_WIN:       state_d = ST_WIN;
            ST_LOSE:      state_d = ST_LOSE;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign killLeft = X_W'(START_X + int'(idx_q) * (ALIEN_W + GAP));

    always_comb begin
        shotHit  = 1'b0;
        killReq  = 1'b0;
        moveDown = 1'b0;
        gameOver = 1'b0;
        youWin   = 1'b0;
        boxTopX  = '0;
        boxBotX  = '0;
        boxTopY  = '0;
        boxBotY  = '0;
        unique case (state_q)
            ST_KILL, ST_WAIT_KILL: begin
                shotHit = (state_q == ST_KILL);
                killReq = 1'b1;
                boxTopX = killLeft;
                boxBotX = killLeft + X_W'(ALIEN_W);
                boxTopY = rowY_q;
                boxBotY = rowY_q + Y_W'(ALIEN_H);
            end
            ST_DROP, ST_WAIT_DROP: begin
                moveDown = 1'b1;
                boxTopX  = ROW_LEFT;
                boxBotX  = ROW_RIGHT;
                boxTopY  = rowY_q;
                boxBotY  = rowY_q + Y_W'(ALIEN_H);
            end
            ST_WIN:  youWin   = 1'b1;
            ST_LOSE: gameOver = 1'b1;
            default: ;
        endcase
    end

    assign killIdx    = idx_q;
    assign rowY       = rowY_q;
    assign alive      = alive_q;
    assign scoreCount = score_q;
    assign dropCount  = drop_q;

endmodule
